pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush controller for the five-stage core (IF, ID, EX, EC, WB). Drives the stall/refresh pair of every inter-stage segment register (if_id, id_ex, ex_ec, ec_wb) from fetch/memory handshakes, hazards and exceptions. Tracks outstanding instruction-bus transactions so stale fetch responses after a flush are discarded. Sequences the EC-stage data request so flushes never tear an in-flight data access.

Parameters:
MAX_OUTST, 2, max outstanding instruction requests; counter width = clog2(MAX_OUTST+1)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
if_req  in  1  IF drives inst request this cycle
inst_addr_ok  in  1  inst bus accepted request
inst_data_ok  in  1  inst bus returned data
ec_data_req  in  1  EC instruction needs data bus
data_addr_ok  in  1  data bus accepted request
data_data_ok  in  1  data bus returned data
id_load_use  in  1  ID load-use hazard
ex_busy  in  1  EX multicycle unit busy
ec_exc  in  1  exception/interrupt at EC
ec_eret  in  1  eret at EC
if_id_stall, id_ex_stall, ex_ec_stall, ec_wb_stall  out  1 each  segment hold
if_id_refresh, id_ex_refresh, ex_ec_refresh, ec_wb_refresh  out  1 each  segment bubble/clear
pc_stall  out  1  hold PC
pc_redirect  out  1  one-cycle pulse: load exception/eret target
inst_discard  out  1  current inst_data_ok belongs to cancelled fetch
data_req_valid  out  1  data request presented to bus
ctrl_state  out  2  data FSM state (debug)

Behaviour:
- Reset (async, resetn=0): all stall/refresh/pc_redirect/inst_discard/data_req_valid = 0; FSM=D_IDLE; outst_cnt=0; cancel_cnt=0; flush_pend=0. All other logic posedge clk.
- Data FSM (encoding 0/1/2): D_IDLE -> D_ADDR when ec_data_req & no flush; D_ADDR: data_req_valid=1, -> D_DATA on data_addr_ok; D_DATA -> D_IDLE on data_data_ok. addr_ok and data_ok same cycle in D_ADDR: -> D_IDLE directly.
- Stall sources, priority downstream first (combinational outputs):
  - mem_wait = state!=D_IDLE & !(state==D_DATA & data_data_ok), or ec_data_req in D_IDLE: pc, if_id, id_ex, ex_ec stall; ec_wb_refresh.
  - else ex_busy: pc, if_id, id_ex stall; ex_ec_refresh.
  - else id_load_use: pc, if_id stall; id_ex_refresh.
  - else fetch_wait (no inst_data_ok, or inst_discard): pc_stall; if_id_refresh.
- A segment never has stall and refresh both 1; refresh wins.
- Flush (ec_exc|ec_eret) in D_IDLE or D_ADDR before addr_ok: same cycle all four refresh=1, stalls=0, pc_redirect=1, FSM->D_IDLE, no data request issued.
- Flush in D_DATA: set flush_pend; keep stalling; apply flush in cycle data_data_ok arrives; clear flush_pend.
- outst_cnt: +1 on if_req&inst_addr_ok, -1 on inst_data_ok; both same cycle: unchanged. Never exceeds MAX_OUTST; at MAX_OUTST pc_stall=1 (no new request).
- On flush: cancel_cnt <= outst_cnt (+1 if accept same cycle, -1 if data_ok same cycle not already discarded). inst_discard = inst_data_ok & cancel_cnt!=0; cancel_cnt decrements per discarded return.
- Flush while cancel_cnt!=0: cancel_cnt <= outst_cnt (recomputed as above).

Optional Feature:
PIPE_CTRL_PERF_EN: adds outputs perf_mem_stall, perf_ex_stall, perf_lu_stall, perf_flush (32-bit each, wrap at 2^32, cleared on reset), incrementing on cycles the respective source is the winning stall/flush. Without macro: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: data FSM state localparams D_IDLE=0/D_ADDR=1/D_DATA=2; segment index constants SEG_IF_ID..SEG_EC_WB.
- Sub-module inst_track: outst_cnt/cancel_cnt/inst_discard logic.

Test Plan:
- Load in EC: ec_data_req=1, addr_ok at cycle 2, data_ok at cycle 4 -> ex_ec_stall=1 cycles 0-3, ec_wb_refresh=1 cycles 0-3, ctrl_state 0->1->2->0.
- ex_busy=1 for 3 cycles with id_load_use=1 -> id_ex_stall=1, ex_ec_refresh=1, id_ex_refresh=0 during busy; after, one cycle id_ex_refresh=1.
- ec_exc with 2 fetches outstanding -> all refresh=1, pc_redirect pulse 1 cycle, next two inst_data_ok have inst_discard=1, third=0.
- ec_exc during D_DATA -> no refresh until data_data_ok cycle, then all refresh=1, pc_redirect=1.
- Async reset asserted mid D_DATA with outst_cnt=2 -> outputs 0 immediately, ctrl_state=0, subsequent inst_data_ok has inst_discard=0.
- MAX_OUTST=2 reached -> pc_stall=1 until an inst_data_ok returns.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control slice: data-bus FSM states,
// segment-register indices and the counter width helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ADDR = 2'd1,
    D_DATA = 2'd2
  } dstate_t;

  localparam int SEG_IF_ID = 0;
  localparam int SEG_ID_EX = 1;
  localparam int SEG_EX_EC = 2;
  localparam int SEG_EC_WB = 3;
  localparam int NUM_SEG   = 4;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/inst_track.sv
// Instruction-bus bookkeeping: counts in-flight fetches and marks returns that
// belong to fetches cancelled by a pipeline flush.
module inst_track
  import cpu_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CW        = cnt_width(MAX_OUTST)
) (
  input  logic clk,
  input  logic resetn,
  input  logic if_req,
  input  logic inst_addr_ok,
  input  logic inst_data_ok,
  input  logic flush,
  output logic inst_discard,
  output logic outst_full
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] outst_cnt, outst_nxt, cancel_cnt;
  logic          inc, dec;

  assign dec = inst_data_ok & (outst_cnt != '0);
  assign inc = if_req & inst_addr_ok & ((outst_cnt != MAX_C) | dec);

  always_comb begin
    outst_nxt = outst_cnt;
    if (inc & ~dec)
      outst_nxt = outst_cnt + ONE_C;
    else if (dec & ~inc)
      outst_nxt = outst_cnt - ONE_C;
  end

  assign inst_discard = inst_data_ok & (cancel_cnt != '0);
  assign outst_full   = (outst_cnt == MAX_C) & ~inst_data_ok;

  // On a flush every fetch still in flight after this cycle is stale,
  // including one accepted this cycle but not one that returned this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      outst_cnt <= outst_nxt;
      if (flush)
        cancel_cnt <= outst_nxt;
      else if (inst_discard)
        cancel_cnt <= cancel_cnt - ONE_C;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the IF-ID-EX-EC-WB pipeline with EC data-bus sequencing.
// Define PIPE_CTRL_PERF_EN to add per-source stall/flush event counters.
//
// state  | meaning
// D_IDLE | no data access in flight
// D_ADDR | data request presented, waiting for data_addr_ok
// D_DATA | request accepted, waiting for data_data_ok
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       if_req,
  input  logic       inst_addr_ok,
  input  logic       inst_data_ok,
  input  logic       ec_data_req,
  input  logic       data_addr_ok,
  input  logic       data_data_ok,
  input  logic       id_load_use,
  input  logic       ex_busy,
  input  logic       ec_exc,
  input  logic       ec_eret,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_ec_stall,
  output logic       ec_wb_stall,
  output logic       if_id_refresh,
  output logic       id_ex_refresh,
  output logic       ex_ec_refresh,
  output logic       ec_wb_refresh,
  output logic       pc_stall,
  output logic       pc_redirect,
  output logic       inst_discard,
  output logic       data_req_valid,
  output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_ex_stall,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush
`endif
);

  dstate_t            state, state_nxt;
  logic               flush_pend;
  logic               flush_req, in_flight, txn_done, flush_now, mem_wait;
  logic               fetch_wait, discard_c, outst_full;
  logic               pc_stall_c, pc_redirect_c;
  logic [NUM_SEG-1:0] seg_stall, seg_refresh, stall_eff;

  inst_track #(.MAX_OUTST(MAX_OUTST)) u_inst_track (
    .clk          (clk),
    .resetn       (resetn),
    .if_req       (if_req),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .flush        (flush_now),
    .inst_discard (discard_c),
    .outst_full   (outst_full)
  );

  // A flush is held off while an accepted data access has yet to return,
  // so the bus transaction is never torn.
  assign in_flight = ((state == D_ADDR) & data_addr_ok & ~data_data_ok)
                   | ((state == D_DATA) & ~data_data_ok);
  assign txn_done  = ((state == D_DATA) & data_data_ok)
                   | ((state == D_ADDR) & data_addr_ok & data_data_ok);
  assign flush_req = ec_exc | ec_eret | flush_pend;
  assign flush_now = flush_req & ~in_flight;
  assign mem_wait  = (state == D_IDLE) ? ec_data_req : ~txn_done;
  assign fetch_wait = ~inst_data_ok | discard_c;

  always_comb begin
    state_nxt = state;
    case (state)
      D_IDLE: if (ec_data_req & ~flush_now) state_nxt = D_ADDR;
      D_ADDR: begin
        if (data_addr_ok)
          state_nxt = data_data_ok ? D_IDLE : D_DATA;
        else if (flush_now)
          state_nxt = D_IDLE;
      end
      D_DATA: if (data_data_ok) state_nxt = D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= D_IDLE;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_req & ~flush_now;
    end
  end

  always_comb begin
    seg_stall     = '0;
    seg_refresh   = '0;
    pc_stall_c    = 1'b0;
    pc_redirect_c = 1'b0;
    if (flush_now) begin
      seg_refresh   = '1;
      pc_redirect_c = 1'b1;
    end else begin
      if (mem_wait) begin
        pc_stall_c             = 1'b1;
        seg_stall[SEG_IF_ID]   = 1'b1;
        seg_stall[SEG_ID_EX]   = 1'b1;
        seg_stall[SEG_EX_EC]   = 1'b1;
        seg_refresh[SEG_EC_WB] = 1'b1;
      end else if (ex_busy) begin
        pc_stall_c             = 1'b1;
        seg_stall[SEG_IF_ID]   = 1'b1;
        seg_stall[SEG_ID_EX]   = 1'b1;
        seg_refresh[SEG_EX_EC] = 1'b1;
      end else if (id_load_use) begin
        pc_stall_c             = 1'b1;
        seg_stall[SEG_IF_ID]   = 1'b1;
        seg_refresh[SEG_ID_EX] = 1'b1;
      end else if (fetch_wait) begin
        pc_stall_c             = 1'b1;
        seg_refresh[SEG_IF_ID] = 1'b1;
      end
      if (outst_full)
        pc_stall_c = 1'b1;
    end
  end

  assign stall_eff = seg_stall & ~seg_refresh;

  // Controls are forced low while reset is asserted, independent of inputs.
  assign if_id_stall    = resetn & stall_eff[SEG_IF_ID];
  assign id_ex_stall    = resetn & stall_eff[SEG_ID_EX];
  assign ex_ec_stall    = resetn & stall_eff[SEG_EX_EC];
  assign ec_wb_stall    = resetn & stall_eff[SEG_EC_WB];
  assign if_id_refresh  = resetn & seg_refresh[SEG_IF_ID];
  assign id_ex_refresh  = resetn & seg_refresh[SEG_ID_EX];
  assign ex_ec_refresh  = resetn & seg_refresh[SEG_EX_EC];
  assign ec_wb_refresh  = resetn & seg_refresh[SEG_EC_WB];
  assign pc_stall       = resetn & pc_stall_c;
  assign pc_redirect    = resetn & pc_redirect_c;
  assign inst_discard   = resetn & discard_c;
  assign data_req_valid = resetn & (state == D_ADDR);
  assign ctrl_state     = state;

`ifdef PIPE_CTRL_PERF_EN
  logic src_mem, src_ex, src_lu;

  assign src_mem = ~flush_now & mem_wait;
  assign src_ex  = ~flush_now & ~mem_wait & ex_busy;
  assign src_lu  = ~flush_now & ~mem_wait & ~ex_busy & id_load_use;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_mem_stall <= '0;
      perf_ex_stall  <= '0;
      perf_lu_stall  <= '0;
      perf_flush     <= '0;
    end else begin
      if (src_mem)   perf_mem_stall <= perf_mem_stall + 32'd1;
      if (src_ex)    perf_ex_stall  <= perf_ex_stall + 32'd1;
      if (src_lu)    perf_lu_stall  <= perf_lu_stall + 32'd1;
      if (flush_now) perf_flush     <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int MAX_OUTST = 2;

  // stimulus bit positions in a 10-bit input vector
  localparam int I_IREQ = 9, I_IAOK = 8, I_IOK = 7, I_DREQ = 6, I_AOK = 5;
  localparam int I_DOK = 4, I_LU = 3, I_BUSY = 2, I_EXC = 1, I_ERET = 0;

  logic clk = 1'b0;
  logic resetn;
  logic if_req, inst_addr_ok, inst_data_ok, ec_data_req, data_addr_ok, data_data_ok;
  logic id_load_use, ex_busy, ec_exc, ec_eret;
  logic if_id_stall, id_ex_stall, ex_ec_stall, ec_wb_stall;
  logic if_id_refresh, id_ex_refresh, ex_ec_refresh, ec_wb_refresh;
  logic pc_stall, pc_redirect, inst_discard, data_req_valid;
  logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_mem_stall, perf_ex_stall, perf_lu_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .ec_data_req(ec_data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .id_load_use(id_load_use), .ex_busy(ex_busy), .ec_exc(ec_exc), .ec_eret(ec_eret),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_ec_stall(ex_ec_stall), .ec_wb_stall(ec_wb_stall),
    .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
    .ex_ec_refresh(ex_ec_refresh), .ec_wb_refresh(ec_wb_refresh),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect), .inst_discard(inst_discard),
    .data_req_valid(data_req_valid), .ctrl_state(ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_mem_stall(perf_mem_stall), .perf_ex_stall(perf_ex_stall),
    .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each queue entry is one outstanding fetch, 1 = cancelled.
  bit fq[$];
  int ph = 0;          // 0 idle, 1 address phase, 2 data phase
  bit pend = 1'b0;

  function automatic bit hold_m(input logic [9:0] v);
    return (ph == 1 && v[I_AOK] && !v[I_DOK]) || (ph == 2 && !v[I_DOK]);
  endfunction

  function automatic bit flush_now_m(input logic [9:0] v);
    return (v[I_EXC] || v[I_ERET] || pend) && !hold_m(v);
  endfunction

  // packed as {pc_stall, 4 stalls, 4 refreshes, redirect, discard, data_req_valid, state}
  function automatic logic [13:0] model_out(input logic [9:0] v);
    bit fn, disc, mem, pc, s1, s2, s3, r1, r2, r3, r4, rd;
    fn   = flush_now_m(v);
    disc = v[I_IOK] && fq.size() > 0 && fq[0];
    mem  = (ph != 0 && !(ph == 2 && v[I_DOK])) || (ph == 0 && v[I_DREQ]);
    {pc, s1, s2, s3, r1, r2, r3, r4, rd} = '0;
    if (fn) begin
      {r1, r2, r3, r4, rd} = '1;
    end else begin
      if (mem)                        {pc, s1, s2, s3, r4} = '1;
      else if (v[I_BUSY])             {pc, s1, s2, r3} = '1;
      else if (v[I_LU])               {pc, s1, r2} = '1;
      else if (!v[I_IOK] || disc)     {pc, r1} = '1;
      if (fq.size() >= MAX_OUTST && !v[I_IOK]) pc = 1'b1;
    end
    return {pc, s1, s2, s3, 1'b0, r1, r2, r3, r4, rd, disc, (ph == 1), 2'(ph)};
  endfunction

  task automatic model_update(input logic [9:0] v);
    bit fn;
    fn = flush_now_m(v);
    if (v[I_IOK] && fq.size() > 0) void'(fq.pop_front());
    if (v[I_IREQ] && v[I_IAOK]) fq.push_back(1'b0);
    if (fn) foreach (fq[i]) fq[i] = 1'b1;
    pend = (v[I_EXC] || v[I_ERET] || pend) && !fn;
    case (ph)
      0: if (v[I_DREQ] && !fn) ph = 1;
      1: if (v[I_AOK]) ph = v[I_DOK] ? 0 : 2;
         else if (fn) ph = 0;
      2: if (v[I_DOK]) ph = 0;
      default: ph = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {pc_stall, if_id_stall, id_ex_stall, ex_ec_stall, ec_wb_stall,
            if_id_refresh, id_ex_refresh, ex_ec_refresh, ec_wb_refresh,
            pc_redirect, inst_discard, data_req_valid, ctrl_state};
  endfunction

  // Called 1ns after a rising edge; samples at the falling edge.
  task automatic step(input logic [9:0] v, input logic [13:0] exp, input bit use_exp,
                      input string name, output logic [13:0] got);
    logic [13:0] mexp;
    {if_req, inst_addr_ok, inst_data_ok, ec_data_req, data_addr_ok,
     data_data_ok, id_load_use, ex_busy, ec_exc, ec_eret} = v;
    mexp = model_out(v);
    #4;
    got = outs();
    check({name, "_model"}, got, mexp);
    if (use_exp) check(name, got, exp);
    model_update(v);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [9:0]  in;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [13];
  logic [13:0] got;
  localparam logic [9:0]  V_IDLE = 10'b0;
  localparam logic [9:0]  V_ACC  = 10'b1100000000;
  localparam logic [9:0]  V_IOK  = 10'b0010000000;
  localparam logic [9:0]  V_DREQ = 10'b0001000000;

  initial begin
    // load in EC: addr_ok at cycle 2, data_ok at cycle 4
    tbl[0]  = '{10'b0001000000, 14'b11110_0001_000_00};
    tbl[1]  = '{10'b0001000000, 14'b11110_0001_001_01};
    tbl[2]  = '{10'b0001100000, 14'b11110_0001_001_01};
    tbl[3]  = '{10'b0001000000, 14'b11110_0001_000_10};
    tbl[4]  = '{10'b0001010000, 14'b10000_1000_000_10};
    tbl[5]  = '{10'b0000000000, 14'b10000_1000_000_00};
    // ex_busy over a load-use hazard, then the hazard alone
    tbl[6]  = '{10'b0000001100, 14'b11100_0010_000_00};
    tbl[7]  = '{10'b0000001100, 14'b11100_0010_000_00};
    tbl[8]  = '{10'b0000001100, 14'b11100_0010_000_00};
    tbl[9]  = '{10'b0000001000, 14'b11000_0100_000_00};
    tbl[10] = '{10'b0000000000, 14'b10000_1000_000_00};
    // one fetch issued and returned
    tbl[11] = '{10'b1100000000, 14'b10000_1000_000_00};
    tbl[12] = '{10'b0010000000, 14'b00000_0000_000_00};

    {if_req, inst_addr_ok, inst_data_ok, ec_data_req, data_addr_ok,
     data_data_ok, id_load_use, ex_busy, ec_exc, ec_eret} = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 check("reset_outputs", outs(), 14'b0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      step(tbl[i].in, tbl[i].exp, 1'b1, $sformatf("tbl%0d", i), got);

    // outstanding limit: PC held until a response returns
    step(V_ACC, '0, 1'b0, "max_acc1", got);
    step(V_ACC, '0, 1'b0, "max_acc2", got);
    step(V_IDLE, '0, 1'b0, "max_full", got);
    check("max_pc_stall", 14'(got[13]), 14'd1);
    step(V_IOK, '0, 1'b0, "max_ret", got);
    check("max_pc_release", 14'(got[13]), 14'd0);
    step(V_IOK, '0, 1'b0, "max_drain", got);

    // exception with two fetches outstanding
    step(V_ACC, '0, 1'b0, "exc_acc1", got);
    step(V_ACC, '0, 1'b0, "exc_acc2", got);
    step(10'b0000000010, 14'b00000_1111_100_00, 1'b1, "exc_flush", got);
    step(V_IDLE, '0, 1'b0, "exc_after", got);
    check("exc_redirect_pulse", 14'(got[4]), 14'd0);
    step(V_IOK, '0, 1'b0, "exc_ret1", got);
    check("exc_discard1", 14'(got[3]), 14'd1);
    step(V_IOK, '0, 1'b0, "exc_ret2", got);
    check("exc_discard2", 14'(got[3]), 14'd1);
    step(V_ACC, '0, 1'b0, "exc_acc3", got);
    step(V_IOK, '0, 1'b0, "exc_ret3", got);
    check("exc_discard3", 14'(got[3]), 14'd0);

    // exception while a data access is in flight
    step(V_DREQ, '0, 1'b0, "dflush_req", got);
    step(10'b0001100000, '0, 1'b0, "dflush_aok", got);
    step(10'b0001000010, 14'b11110_0001_000_10, 1'b1, "dflush_held", got);
    step(V_DREQ, 14'b11110_0001_000_10, 1'b1, "dflush_pend", got);
    step(10'b0001010000, 14'b00000_1111_100_10, 1'b1, "dflush_apply", got);
    step(V_IDLE, 14'b10000_1000_000_00, 1'b1, "dflush_done", got);

    // asynchronous reset in the data phase with two fetches outstanding
    step(V_ACC, '0, 1'b0, "rst_acc1", got);
    step(V_ACC, '0, 1'b0, "rst_acc2", got);
    step(V_DREQ, '0, 1'b0, "rst_req", got);
    step(10'b0001100000, '0, 1'b0, "rst_aok", got);
    {if_req, inst_addr_ok, inst_data_ok, ec_data_req, data_addr_ok,
     data_data_ok, id_load_use, ex_busy, ec_exc, ec_eret} = V_DREQ;
    #2 resetn = 1'b0;
    #1 check("rst_async_outputs", outs(), 14'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    fq.delete();
    ph = 0;
    pend = 1'b0;
    step(V_IOK, '0, 1'b0, "rst_ret", got);
    check("rst_no_discard", 14'(got[3]), 14'd0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [9:0] v;
      v = '0;
      v[I_IREQ] = 1'($urandom_range(0, 1));
      v[I_IAOK] = v[I_IREQ] && fq.size() < MAX_OUTST && ($urandom_range(0, 2) != 0);
      v[I_IOK]  = fq.size() > 0 && ($urandom_range(0, 1) == 1);
      v[I_DREQ] = (ph != 0) || ($urandom_range(0, 2) == 0);
      v[I_AOK]  = (ph == 1) && ($urandom_range(0, 1) == 1);
      v[I_DOK]  = (ph == 2) && ($urandom_range(0, 1) == 1);
      v[I_LU]   = ($urandom_range(0, 3) == 0);
      v[I_BUSY] = ($urandom_range(0, 3) == 0);
      v[I_EXC]  = ($urandom_range(0, 19) == 0);
      v[I_ERET] = ($urandom_range(0, 29) == 0);
      step(v, '0, 1'b0, "rand", got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
